// File: rtl/inst_issue_buffer.sv
`default_nettype none
// ============================================================================
// Module      : inst_issue_buffer
// Description : FIFO that decouples {PC, instruction} pairs from the controller
//               and re-issues them downstream over valid/ready. Stalls when full.
//               Optional performance counters: INST_ISSUE_BUF_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_issue_buffer #(
    parameter int InstWidth = 32,
    parameter int PcWidth   = 7,
    parameter int Depth     = 2,
    parameter int CntWidth  = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clr_i,
    input  logic                         inst_valid_i,
    input  logic [PcWidth-1:0]           inst_pc_i,
    input  logic [InstWidth-1:0]         inst_i,
    output logic                         stall_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [PcWidth-1:0]           out_pc_o,
    output logic [InstWidth-1:0]         out_inst_o,
    output logic [$clog2(Depth+1)-1:0]   count_o,
    output logic [CntWidth-1:0]          stall_cnt_o,
    output logic [CntWidth-1:0]          issue_cnt_o
);

    localparam int PtrWidth   = $clog2(Depth);
    localparam int CountWidth = $clog2(Depth+1);
    localparam int EntryWidth = PcWidth + InstWidth;
    localparam logic [CountWidth-1:0] FullCount = CountWidth'(Depth);

    logic [EntryWidth-1:0] mem_q [Depth];
    logic [EntryWidth-1:0] mem_d [Depth];
    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  full, empty, push, pop;

    // Flags come from registered count only, keeping stall_o free of input paths.
    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);
    assign push  = inst_valid_i && !full;
    assign pop   = !empty && out_ready_i;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {inst_pc_i, inst_i};
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign stall_o                = full;
    assign out_valid_o            = !empty;
    assign {out_pc_o, out_inst_o} = mem_q[rd_ptr_q];
    assign count_o                = count_q;

`ifdef INST_ISSUE_BUF_PERF_CNT_EN
    logic [CntWidth-1:0] stall_cnt_q, stall_cnt_d;
    logic [CntWidth-1:0] issue_cnt_q, issue_cnt_d;

    // Both counters saturate rather than wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        issue_cnt_d = issue_cnt_q;
        if (clr_i) begin
            stall_cnt_d = '0;
            issue_cnt_d = '0;
        end else begin
            if (inst_valid_i && full && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (pop && (issue_cnt_q != '1)) begin
                issue_cnt_d = issue_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            issue_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign issue_cnt_o = issue_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign issue_cnt_o = '0;
`endif

endmodule
`default_nettype wire
